// File: rtl/pattern_gen_check_if.sv
// pattern_gen_check_if
//   Groups the pipe-out (generator) and pipe-in (checker) strobes and data
//   between the host endpoints and pattern_gen_check.
//   gen_read  : pipe-out ep_read strobe        (master -> slave)
//   gen_data  : pipe-out ep_datain, registered (slave  -> master)
//   chk_write : pipe-in ep_write strobe        (master -> slave)
//   chk_data  : pipe-in ep_dataout             (master -> slave)
interface pattern_gen_check_if #(
  parameter int unsigned WIDTH = 32
);
  logic             gen_read;
  logic [WIDTH-1:0] gen_data;
  logic             chk_write;
  logic [WIDTH-1:0] chk_data;

  modport master (output gen_read, output chk_write, output chk_data, input gen_data);
  modport slave  (input gen_read, input chk_write, input chk_data, output gen_data);
endinterface

// File: rtl/pattern_gen_check.sv
// pattern_gen_check
//   Pattern generator (pipe-out side) and independent pattern checker
//   (pipe-in side) for host throughput/integrity tests, all on okClk.
//   Patterns: 00 off, 01 LFSR, 10 counter, 11 walking-one.
// Ports:
//   okClk, reset    : clock, asynchronous active-high reset
//   mode, seed      : pattern mode and seed value
//   seed_load       : one-cycle pulse, loads sanitised seed into both sides and
//                     clears checker statistics; drops coincident strobes
//   inject_err      : error-injection request pulse
//   pipe (slave)    : gen_read/gen_data, chk_write/chk_data
//   word_count      : words checked (saturating)
//   err_count       : mismatching words (saturating)
//   first_err_idx   : word_count value at the first mismatch
//   first_err_valid : first_err_idx holds a captured value
// Build option: define PATTERN_GEN_CHECK_ERR_INJECT_EN to build the
//   injection logic (one LSB-flipped generator word per armed request).
module pattern_gen_check #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(32'h8020_0002),
  parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1),
  parameter int unsigned      CNT_W    = 32
) (
  input  logic                okClk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    seed,
  input  logic                seed_load,
  input  logic                inject_err,
  pattern_gen_check_if.slave  pipe,
  output logic [CNT_W-1:0]    word_count,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    first_err_idx,
  output logic                first_err_valid
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_LFSR = 2'b01,
    MODE_CNT  = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  mode_e            cur_mode;
  logic [WIDTH-1:0] gen_state;
  logic [WIDTH-1:0] chk_state;
  logic [WIDTH-1:0] seed_clean;
  logic [WIDTH-1:0] flip;
  logic             gen_adv;
  logic             chk_adv;
  logic             mismatch;

  assign cur_mode = mode_e'(mode);

  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] s, input mode_e m);
    case (m)
      MODE_LFSR: return {s[WIDTH-2:0], ^(s & TAPS)};
      MODE_CNT:  return s + WIDTH'(1);
      MODE_WALK: return {s[WIDTH-2:0], s[WIDTH-1]};
      default:   return s;
    endcase
  endfunction

  // A zero seed would lock LFSR and walking-one patterns at zero forever.
  always_comb begin
    seed_clean = seed;
    if ((cur_mode == MODE_LFSR || cur_mode == MODE_WALK) && seed == '0)
      seed_clean = WIDTH'(1);
  end

  assign gen_adv  = pipe.gen_read  && !seed_load && cur_mode != MODE_OFF;
  assign chk_adv  = pipe.chk_write && !seed_load && cur_mode != MODE_OFF;
  assign mismatch = pipe.chk_data != chk_state;

`ifdef PATTERN_GEN_CHECK_ERR_INJECT_EN
  logic arm;

  // An advance consumes the arm; a request in that same cycle re-arms for
  // the following advance. Repeated requests while armed collapse into one.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset)            arm <= 1'b0;
    else if (seed_load)   arm <= 1'b0;
    else if (gen_adv)     arm <= inject_err;
    else if (inject_err)  arm <= 1'b1;
  end

  assign flip = {{(WIDTH-1){1'b0}}, arm};
`else
  logic unused_inject;
  assign unused_inject = inject_err;
  assign flip          = '0;
`endif

  // Generator
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      gen_state     <= SEED_RST;
      pipe.gen_data <= '0;
    end else if (seed_load) begin
      gen_state <= seed_clean;
    end else if (pipe.gen_read) begin
      if (cur_mode != MODE_OFF) begin
        pipe.gen_data <= gen_state ^ flip;
        gen_state     <= next_word(gen_state, cur_mode);
      end else begin
        pipe.gen_data <= '0;
      end
    end
  end

  // Checker
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      chk_state       <= SEED_RST;
      word_count      <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (seed_load) begin
      chk_state       <= seed_clean;
      word_count      <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (chk_adv) begin
      chk_state <= next_word(chk_state, cur_mode);
      if (word_count != '1)
        word_count <= word_count + CNT_W'(1);
      if (mismatch) begin
        if (err_count != '1)
          err_count <= err_count + CNT_W'(1);
        if (!first_err_valid) begin
          first_err_idx   <= word_count;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen_check.sv
// tb_pattern_gen_check
//   Drives pattern_gen_check with directed and random strobes. A reference
//   model computes every expected generator word and checker status; those
//   are queued at issue time and popped by an independent monitor.
module tb_pattern_gen_check;

  localparam int unsigned     W      = 32;
  localparam int unsigned     CW     = 5;
  localparam logic [W-1:0]    TAPS_M = 32'h8020_0002;
  localparam int              CMAX   = (1 << CW) - 1;

  logic          okClk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  seed = '0;
  logic          seed_load = 1'b0;
  logic          inject_err = 1'b0;
  logic [CW-1:0] word_count, err_count, first_err_idx;
  logic          first_err_valid;

  pattern_gen_check_if #(.WIDTH(W)) pipe ();

  pattern_gen_check #(.WIDTH(W), .CNT_W(CW)) dut (
    .okClk           (okClk),
    .reset           (reset),
    .mode            (mode),
    .seed            (seed),
    .seed_load       (seed_load),
    .inject_err      (inject_err),
    .pipe            (pipe.slave),
    .word_count      (word_count),
    .err_count       (err_count),
    .first_err_idx   (first_err_idx),
    .first_err_valid (first_err_valid)
  );

  always #5 okClk = ~okClk;

  typedef struct packed {
    logic [CW-1:0] wc;
    logic [CW-1:0] ec;
    logic [CW-1:0] fi;
    logic          fv;
  } status_t;

  logic [W-1:0] gen_q[$];
  status_t      st_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] m_gen, m_chk, m_gdata;
  int           m_wc, m_ec, m_fi;
  bit           m_fv, m_arm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] m_next(input logic [W-1:0] s, input logic [1:0] md);
    case (md)
      2'b01:   return (s << 1) | W'($countones(s & TAPS_M) % 2);
      2'b10:   return s + W'(1);
      2'b11:   return (s << 1) | (s >> (W - 1));
      default: return s;
    endcase
  endfunction

  function automatic status_t m_status();
    return '{wc: CW'(m_wc), ec: CW'(m_ec), fi: CW'(m_fi), fv: m_fv};
  endfunction

  task automatic model_reset();
    m_gen = W'(1); m_chk = W'(1); m_gdata = '0;
    m_wc = 0; m_ec = 0; m_fi = 0; m_fv = 0; m_arm = 0;
  endtask

  // One clock of stimulus; the model is advanced with the same inputs.
  task automatic cycle(input bit rd, input bit wr, input logic [W-1:0] data,
                       input bit ld, input logic [W-1:0] sd, input bit inj);
    logic [W-1:0] san;
    pipe.gen_read  = rd;
    pipe.chk_write = wr;
    pipe.chk_data  = data;
    seed_load      = ld;
    seed           = sd;
    inject_err     = inj;
    if (ld) begin
      san = ((mode == 2'b01 || mode == 2'b11) && sd == 0) ? W'(1) : sd;
      m_gen = san; m_chk = san;
      m_wc = 0; m_ec = 0; m_fi = 0; m_fv = 0; m_arm = 0;
    end else begin
      if (rd) begin
        if (mode != 2'b00) begin
          m_gdata = m_gen ^ W'(m_arm);
          m_gen   = m_next(m_gen, mode);
          m_arm   = 0;
        end else begin
          m_gdata = '0;
        end
      end
      if (wr && mode != 2'b00) begin
        if (data != m_chk) begin
          if (!m_fv) begin m_fi = m_wc; m_fv = 1; end
          if (m_ec < CMAX) m_ec++;
        end
        if (m_wc < CMAX) m_wc++;
        m_chk = m_next(m_chk, mode);
      end
`ifdef PATTERN_GEN_CHECK_ERR_INJECT_EN
      if (inj) m_arm = 1;
`endif
    end
    if (rd) gen_q.push_back(m_gdata);
    if (wr) st_q.push_back(m_status());
    @(posedge okClk);
    #1;
    pipe.gen_read = 0; pipe.chk_write = 0; seed_load = 0; inject_err = 0;
  endtask

  task automatic rd1();                       cycle(1, 0, '0, 0, '0, 0); endtask
  task automatic wr1(input logic [W-1:0] d);  cycle(0, 1, d, 0, '0, 0);  endtask
  task automatic ld1(input logic [W-1:0] s);  cycle(0, 0, '0, 1, s, 0);  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gen_data"}, pipe.gen_data, 0);
    check({tag, "_word_count"}, word_count, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err_idx"}, first_err_idx, 0);
    check({tag, "_first_err_valid"}, first_err_valid, 0);
  endtask

  // monitor: strobes accepted at a rising edge are checked on the next falling edge
  bit rd_edge = 0, wr_edge = 0;
  always @(posedge okClk) begin
    rd_edge <= pipe.gen_read && !reset;
    wr_edge <= pipe.chk_write && !reset;
  end

  always @(negedge okClk) begin
    logic [W-1:0] eg;
    status_t      es;
    if (rd_edge) begin
      if (gen_q.size() == 0) check("gen_q_underflow", 1, 0);
      else begin eg = gen_q.pop_front(); check("gen_data", pipe.gen_data, eg); end
    end
    if (wr_edge) begin
      if (st_q.size() == 0) check("st_q_underflow", 1, 0);
      else begin
        es = st_q.pop_front();
        check("status", {word_count, err_count, first_err_idx, first_err_valid}, es);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    pipe.gen_read = 0; pipe.chk_write = 0; pipe.chk_data = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge okClk);
    #1 reset = 0;

    // counter, seed 0x10
    mode = 2'b10;
    ld1(32'h10);
    repeat (3) rd1();

    // LFSR, zero seed sanitised to 1
    mode = 2'b01;
    ld1(32'h0);
    repeat (5) rd1();

    // counter loopback with word 3 corrupted, reads alongside writes
    mode = 2'b10;
    ld1(32'h10);
    for (int unsigned i = 0; i < 8; i++)
      cycle(1, 1, (i == 3) ? 32'h93 : 32'h10 + i, 0, '0, 0);
    check("loop_word_count", word_count, 8);
    check("loop_err_count", err_count, 1);
    check("loop_first_err_idx", first_err_idx, 3);
    check("loop_first_err_valid", first_err_valid, 1);

    // counter wrap at 2^W
    ld1(32'hFFFF_FFFE);
    repeat (3) rd1();

    // saturation of both counters
    ld1(32'h0);
    for (int unsigned i = 0; i < 40; i++) wr1(~m_chk);
    check("sat_word_count", word_count, CMAX);
    check("sat_err_count", err_count, CMAX);
    check("sat_first_err_idx", first_err_idx, 0);

    // walking-one wraps through the MSB
    mode = 2'b11;
    ld1(32'h8000_0000);
    repeat (3) rd1();

    // mode off: reads return zero, writes ignored, state held
    mode = 2'b00;
    rd1();
    wr1(32'h1234_5678);
    mode = 2'b11;
    rd1();

    // seed_load wins over coincident strobes
    mode = 2'b10;
    ld1(32'h30);
    rd1();
    cycle(1, 1, 32'hDEAD_BEEF, 1, 32'h40, 0);
    rd1();
    wr1(32'h40);

    // mode change mid-stream keeps state
    ld1(32'h5);
    repeat (2) rd1();
    mode = 2'b11;
    repeat (2) rd1();

    // error injection request followed by loopback of the generated words
    mode = 2'b10;
    ld1(32'h20);
    cycle(0, 0, '0, 0, '0, 1);
    repeat (3) rd1();
    wr1(32'h21); wr1(32'h21); wr1(32'h22);
    check("inj_err_count", err_count, 1);
    check("inj_first_err_idx", first_err_idx, 0);
    check("inj_first_err_valid", first_err_valid, 1);

    // randomised traffic
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) mode = 2'($urandom);
      d = ($urandom_range(3) == 0) ? W'($urandom) : m_chk;
      cycle(1'($urandom), 1'($urandom), d, $urandom_range(15) == 0,
            ($urandom_range(3) == 0) ? '0 : W'($urandom), 0);
    end

    // asynchronous reset between two reads
    mode = 2'b10;
    ld1(32'h100);
    rd1();
    wr1(32'h100);
    @(negedge okClk);
    #1 reset = 1;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(negedge okClk);
    #1 reset = 0;
    rd1();
    wr1(32'h1);
    check("post_reset_word_count", word_count, 1);
    check("post_reset_err_count", err_count, 0);

    repeat (3) @(posedge okClk);
    #1;
    check("gen_q_drained", gen_q.size(), 0);
    check("st_q_drained", st_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_gen_check.md
# pattern_gen_check

Parametrised pattern generator and checker for host pipe throughput and integrity tests. The generator produces one word per pipe-out read strobe. The checker compares each pipe-in write against an independently advanced expected sequence, and counts words, errors and the first error index. Both sides sit directly behind okPipeOut / okPipeIn endpoints on okClk. Mode, seed and load pulse come from wire-in and trigger-in endpoints, and status goes to wire-outs.

## Interface

Parameters
- WIDTH, 32: data word width, legal range 8..64.
- TAPS, 32'h8020_0002: LFSR feedback mask (bits 31, 21, 1). Width is WIDTH.
- SEED_RST, 1: generator and checker state after reset.
- CNT_W, 32: width of all counters and the error index.

Ports
- okClk, in, 1: sole clock. All logic is on the rising edge.
- reset, in, 1: asynchronous, active-high.
- mode, in, 2: pattern mode.
  - 00 off
  - 01 LFSR
  - 10 counter
  - 11 walking-one
- seed, in, WIDTH: value loaded on seed_load.
- seed_load, in, 1: single-cycle pulse.
- gen_read, in, 1: pipe-out ep_read.
- gen_data, out, WIDTH: pipe-out ep_datain, registered.
- chk_write, in, 1: pipe-in ep_write.
- chk_data, in, WIDTH: pipe-in ep_dataout.
- word_count, out, CNT_W: words checked, saturating.
- err_count, out, CNT_W: mismatches, saturating.
- first_err_idx, out, CNT_W: word_count value at the first mismatch.
- first_err_valid, out, 1: first_err_idx holds a captured value.
- inject_err, in, 1: error-injection request pulse. Only used when the macro is defined.

## Operation

- State registers gen_state and chk_state, each WIDTH wide.
- Next-state function next(s) depends on mode:
  - LFSR: {s[WIDTH-2:0], ^(s & TAPS)}.
  - Counter: s + 1, wrapping modulo 2^WIDTH.
  - Walking-one: rotate s left by 1.
  - Off: s, unchanged.
- Seed sanitising: in LFSR or walking-one mode, a zero seed loads 1. Counter mode loads the seed as given.
- seed_load:
  - gen_state and chk_state both take the sanitised seed.
  - word_count, err_count, first_err_idx and first_err_valid clear.
  - gen_data is unchanged.
- Generator, on gen_read with mode ≠ 00:
  - gen_data <= gen_state.
  - gen_state <= next(gen_state).
- Generator, on gen_read with mode = 00: gen_data <= 0, and state holds.
- Checker, on chk_write with mode ≠ 00:
  - Compare chk_data with chk_state.
  - chk_state <= next(chk_state).
  - word_count increments.
  - On mismatch, err_count increments. If first_err_valid = 0, first_err_idx <= word_count (its pre-increment value) and first_err_valid <= 1.
- Checker, on chk_write with mode = 00: the write is ignored.
- Both counters saturate at 2^CNT_W − 1 and never wrap.
- Priority rules:
  - seed_load wins over gen_read and chk_write in the same cycle; those strobes are dropped.
  - gen_read and chk_write are independent and may coincide.
- Mode change mid-stream: state is not reset. The new next() applies from the next advance onward.
- Reset values:
  - gen_state and chk_state = SEED_RST.
  - gen_data = 0.
  - All counters = 0, first_err_idx = 0, first_err_valid = 0.
  - Injection arm flag = 0.
- Reset asserted mid-stream: all of the above apply immediately and asynchronously. The first strobe after release uses SEED_RST.

## Timing

- gen_data is valid on the cycle after the gen_read edge, matching the pipe-out contract.
- Back-to-back gen_read strobes yield consecutive pattern words with no bubbles.
- Status outputs reflect a chk_write one cycle after its edge.
- seed_load takes effect on the next edge. A strobe on the following cycle already uses the new seed.
- No combinational path from any input to any output.

## Configuration

- Macro: PATTERN_GEN_CHECK_ERR_INJECT_EN.
- Defined:
  - An inject_err pulse sets an arm flag.
  - On the next generator advance, gen_data is next word ^ 1 (LSB flipped). gen_state advances normally and the arm flag clears.
  - seed_load and reset clear the arm flag.
  - Multiple pulses while armed produce one corruption.
- Undefined: inject_err stays on the port list but is ignored, and no arm logic is built.

## Test plan

- Counter mode, seed 0x10, 3 reads -> gen_data 0x10, 0x11, 0x12, each one cycle after its read.
- LFSR mode, WIDTH=32, default TAPS, seed 0 (sanitised to 1), 5 reads -> 0x1, 0x2, 0x5, 0xA, 0x15.
- Counter mode, loopback of 8 words from seed 0x10 with word 3 forced to 0x93 -> word_count 8, err_count 1, first_err_idx 3, first_err_valid 1.
- WIDTH=8, CNT_W=4, counter mode, seed 0xFE, 3 reads -> 0xFE, 0xFF, 0x00; then 20 mismatching writes -> err_count 15, word_count 15.
- Reset asserted mid-stream between two reads -> all outputs zero immediately; first read after release returns SEED_RST.
- Macro defined, counter mode, seed 0x20, inject_err then 3 reads -> 0x21, 0x21, 0x22; looped back -> err_count 1, first_err_idx 0.
